bft_config_loader: RTL and testbench

//   Sequencer that replays a stored list of BFT routing-configuration packets into a leaf input port.
//   The list is a 49-bit leaf word per entry ({valid, 48-bit payload}); each operator link is two consecutive entries.

---
 rtl/bft_config_loader.sv | 241 ++++++++++++++++++++++++
 tb/tb_bft_config_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bft_config_loader.sv
`default_nettype none
// ============================================================================
//  Module   : bft_config_loader
//  Purpose  : Replays a stored list of BFT routing-configuration packets into
//             a leaf input port, waits a settle interval after the last
//             accepted packet, then pulses ap_start to the operator graph.
//  Revision : 1.0 - initial release
//
//  Optional feature macro: CFG_CHECKSUM_EN
//      defined   -> cfg_checksum XOR-accumulates every transferred payload
//      undefined -> cfg_checksum is tied to 0, no accumulator is built
//
//  Ports
//      clk_bft      in   1            sole clock, rising edge
//      reset_n      in   1            synchronous active-low reset
//      tbl_we       in   1            table write strobe (honoured only in IDLE)
//      tbl_addr     in   ADDR_W       table write address
//      tbl_wdata    in   PAYLOAD_W    table write payload
//      num_pkts     in   ADDR_W+1     entries to send, sampled at cfg_start
//      cfg_start    in   1            start request (acted on only in IDLE)
//      leaf_out     out  PAYLOAD_W+1  {valid, payload} towards the leaf
//      leaf_ready   in   1            leaf accepts leaf_out this cycle
//      ap_start     out  1            operator-graph start
//      busy         out  1            high in every state except IDLE
//      cfg_done     out  1            one-cycle pulse on return to IDLE
//      tbl_wr_err   out  1            sticky: table write attempted while busy
//      cfg_checksum out  PAYLOAD_W    XOR of transferred payloads
// ============================================================================
module bft_config_loader #(
    parameter int PAYLOAD_W  = 48,
    parameter int ADDR_W     = 6,
    parameter int SETTLE_CYC = 16,
    parameter int START_CYC  = 10
) (
    input  logic                 clk_bft,
    input  logic                 reset_n,
    input  logic                 tbl_we,
    input  logic [ADDR_W-1:0]    tbl_addr,
    input  logic [PAYLOAD_W-1:0] tbl_wdata,
    input  logic [ADDR_W:0]      num_pkts,
    input  logic                 cfg_start,
    output logic [PAYLOAD_W:0]   leaf_out,
    input  logic                 leaf_ready,
    output logic                 ap_start,
    output logic                 busy,
    output logic                 cfg_done,
    output logic                 tbl_wr_err,
    output logic [PAYLOAD_W-1:0] cfg_checksum
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_SEND   = 3'd2;
    localparam logic [2:0] S_SETTLE = 3'd3;
    localparam logic [2:0] S_START  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int TMR_MAX = (SETTLE_CYC > START_CYC) ? SETTLE_CYC : START_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [ADDR_W:0]  MAX_PKTS = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]  ONE_PKT  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W:0]  NO_PKTS  = '0;
    // The settle timer runs from 0 up to SETTLE_CYC inclusive: ap_start then
    // rises SETTLE_CYC+1 edges after the last transfer (or after the start
    // edge for an empty list), leaving SETTLE_CYC fully idle cycles on the leaf.
    localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC);
    localparam logic [TMR_W-1:0] START_LAST  = TMR_W'(START_CYC - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]           r_state;
    logic [ADDR_W:0]      r_cnt;      // transfers still owed to the leaf
    logic [ADDR_W:0]      r_rd_idx;   // next table entry to read
    logic [PAYLOAD_W:0]   r_leaf;     // registered leaf word
    logic [TMR_W-1:0]     r_timer;
    logic                 r_wr_err;
    logic [PAYLOAD_W-1:0] r_rdata;    // table read register (one entry ahead)
    logic [PAYLOAD_W-1:0] mem [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------------
    logic            w_idle;
    logic            w_launch;
    logic            w_xfer;
    logic            w_load;
    logic            w_rd_en;
    logic            w_tbl_wr;
    logic [ADDR_W:0] w_clamped;

    assign w_idle    = (r_state == S_IDLE);
    assign w_launch  = w_idle && cfg_start;
    assign w_xfer    = (r_state == S_SEND) && r_leaf[PAYLOAD_W] && leaf_ready;
    // The leaf register is (re)loaded from the read register on the first SEND
    // cycle and on every transfer except the last one of the run.
    assign w_load    = (r_state == S_SEND) &&
                       (!r_leaf[PAYLOAD_W] || (w_xfer && (r_cnt != ONE_PKT)));
    // Reads stop once the pointer passes the end of the table, so the index
    // never wraps back to entry 0 inside a run.
    assign w_rd_en   = reset_n && ((r_state == S_FETCH) || w_load) && !r_rd_idx[ADDR_W];
    assign w_tbl_wr  = reset_n && w_idle && tbl_we;
    assign w_clamped = (num_pkts > MAX_PKTS) ? MAX_PKTS : num_pkts;

    // ------------------------------------------------------------------------
    // Table RAM: synchronous write in IDLE, synchronous read while sending.
    // Contents are deliberately not reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_bft) begin
        if (w_tbl_wr) begin
            mem[tbl_addr] <= tbl_wdata;
        end
        if (w_rd_en) begin
            r_rdata <= mem[r_rd_idx[ADDR_W-1:0]];
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_bft) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rd_idx <= '0;
            r_leaf   <= '0;
            r_timer  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_cnt    <= w_clamped;
                        r_rd_idx <= '0;
                        r_timer  <= '0;
                        r_state  <= (w_clamped == NO_PKTS) ? S_SETTLE : S_FETCH;
                    end
                end

                S_FETCH: begin
                    r_state <= S_SEND;
                end

                S_SEND: begin
                    if (!r_leaf[PAYLOAD_W]) begin
                        r_leaf <= {1'b1, r_rdata};
                    end else if (leaf_ready) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == ONE_PKT) begin
                            r_leaf  <= '0;
                            r_timer <= '0;
                            r_state <= S_SETTLE;
                        end else begin
                            r_leaf <= {1'b1, r_rdata};
                        end
                    end
                end

                S_SETTLE: begin
                    if (r_timer == SETTLE_LAST) begin
                        r_timer <= '0;
                        r_state <= S_START;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_START: begin
                    if (r_timer == START_LAST) begin
                        r_timer <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Read pointer advances with every issued read (prefetch).
            if (w_rd_en) begin
                r_rd_idx <= r_rd_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Sticky write-while-busy error
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_bft) begin
        if (!reset_n) begin
            r_wr_err <= 1'b0;
        end else if (w_launch) begin
            r_wr_err <= 1'b0;
        end else if (tbl_we && !w_idle) begin
            r_wr_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Optional payload checksum
    // ------------------------------------------------------------------------
`ifdef CFG_CHECKSUM_EN
    logic [PAYLOAD_W-1:0] r_csum;

    always_ff @(posedge clk_bft) begin
        if (!reset_n) begin
            r_csum <= '0;
        end else if (w_launch) begin
            r_csum <= '0;
        end else if (w_xfer) begin
            r_csum <= r_csum ^ r_leaf[PAYLOAD_W-1:0];
        end
    end

    assign cfg_checksum = r_csum;
`else
    assign cfg_checksum = '0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign leaf_out   = r_leaf;
    assign ap_start   = (r_state == S_START);
    assign busy       = !w_idle;
    assign cfg_done   = (r_state == S_DONE);
    assign tbl_wr_err = r_wr_err;

endmodule
`default_nettype wire

// File: tb/tb_bft_config_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bft_config_loader
//  Purpose  : Self-checking bench for bft_config_loader. Keeps a shadow copy
//             of the table and predicts each run at transaction level: the
//             ordered list of words, their first-valid latency, the settle and
//             start windows, the done pulse, the error flag and the checksum.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bft_config_loader;

    localparam int PW  = 48;
    localparam int AW  = 6;
    localparam int SC  = 16;
    localparam int STC = 10;
    localparam int BUDGET = 4000;

    logic          clk_bft;
    logic          reset_n;
    logic          tbl_we;
    logic [AW-1:0] tbl_addr;
    logic [PW-1:0] tbl_wdata;
    logic [AW:0]   num_pkts;
    logic          cfg_start;
    logic [PW:0]   leaf_out;
    logic          leaf_ready;
    logic          ap_start;
    logic          busy;
    logic          cfg_done;
    logic          tbl_wr_err;
    logic [PW-1:0] cfg_checksum;

    bft_config_loader #(
        .PAYLOAD_W  (PW),
        .ADDR_W     (AW),
        .SETTLE_CYC (SC),
        .START_CYC  (STC)
    ) dut (
        .clk_bft      (clk_bft),
        .reset_n      (reset_n),
        .tbl_we       (tbl_we),
        .tbl_addr     (tbl_addr),
        .tbl_wdata    (tbl_wdata),
        .num_pkts     (num_pkts),
        .cfg_start    (cfg_start),
        .leaf_out     (leaf_out),
        .leaf_ready   (leaf_ready),
        .ap_start     (ap_start),
        .busy         (busy),
        .cfg_done     (cfg_done),
        .tbl_wr_err   (tbl_wr_err),
        .cfg_checksum (cfg_checksum)
    );

    initial clk_bft = 1'b0;
    always #5 clk_bft = ~clk_bft;

    int            n_err;
    int            n_chk;
    logic [PW-1:0] model_mem [64];

    typedef struct {
        int n;          // num_pkts driven
        int rmode;      // 0: always ready, 1: random, 2: 1,0,0 repeating
        int exp_xfers;  // transfers the run must make
    } vec_t;

    task automatic tick();
        @(posedge clk_bft);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit pick(input int mode, input int e);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return ((e % 3) == 0);
        endcase
    endfunction

    task automatic wr(input int a, input logic [PW-1:0] d);
        tbl_we    = 1'b1;
        tbl_addr  = AW'(a);
        tbl_wdata = d;
        tick();
        tbl_we    = 1'b0;
        model_mem[a] = d;
    endtask

    // One complete run from cfg_start to the return to IDLE.
    //   we_at    : edge index (from the start edge) before which a write is
    //              attempted while busy; -1 for none
    //   start_at : tail step at which cfg_start is pulsed while busy; -1 none
    //   wr0      : write entry 0 on the same edge that starts the run
    task automatic run(input int n, input int rmode, input int we_at, input int start_at,
                       input bit wr0, output int xfers, output logic [PW-1:0] csum);
        int            nexp;
        int            e;
        int            k;
        bit            rdy;
        logic [63:0]   r64;
        logic [PW-1:0] acc;
        logic [PW-1:0] exp_cs;

        nexp = (n > 64) ? 64 : n;
        acc  = '0;
        num_pkts  = (AW + 1)'(n);
        cfg_start = 1'b1;
        if (wr0) begin
            r64 = {$urandom(), $urandom()};
            tbl_we = 1'b1; tbl_addr = '0; tbl_wdata = r64[PW-1:0];
            model_mem[0] = r64[PW-1:0];
        end
        tick();                               // start edge
        cfg_start = 1'b0;
        tbl_we    = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("wr_err_cleared", {63'd0, tbl_wr_err}, 64'd0);
        chk("leaf_fetch", {15'd0, leaf_out}, 64'd0);

        e = 0;
        k = 0;
        while (k < nexp && e < BUDGET) begin
            rdy = pick(rmode, e);
            leaf_ready = rdy;
            if (e == we_at) begin
                r64 = {$urandom(), $urandom()};
                tbl_we = 1'b1; tbl_addr = AW'(3); tbl_wdata = r64[PW-1:0];
            end else begin
                tbl_we = 1'b0;
            end
            tick();
            e++;
            // Word first valid after edge 2, so the first transfer is at edge 3.
            if (e >= 3 && rdy) begin
                acc = acc ^ model_mem[k];
                k++;
            end
            if (e >= 2 && k < nexp) chk("leaf_word", {15'd0, leaf_out}, {15'd0, 1'b1, model_mem[k]});
            else                    chk("leaf_idle", {15'd0, leaf_out}, 64'd0);
            chk("busy_send", {63'd0, busy}, 64'd1);
        end
        tbl_we = 1'b0;
        if (k < nexp) chk("send_timeout", 64'(k), 64'(nexp));
        if (rmode == 0 && nexp > 0) chk("back_to_back_last_edge", 64'(e), 64'(nexp + 2));

`ifdef CFG_CHECKSUM_EN
        exp_cs = acc;
`else
        exp_cs = '0;
`endif
        // Tail: settle, start window, done pulse, idle.
        for (int j = 1; j <= SC + STC + 2; j++) begin
            leaf_ready = 1'($urandom_range(0, 1));
            cfg_start  = (j == start_at);
            tick();
            chk("tail_leaf", {15'd0, leaf_out}, 64'd0);
            chk("ap_start", {63'd0, ap_start}, {63'd0, (j >= SC + 1 && j <= SC + STC)});
            chk("cfg_done", {63'd0, cfg_done}, {63'd0, (j == SC + STC + 1)});
            chk("busy_tail", {63'd0, busy}, {63'd0, (j <= SC + STC + 1)});
            if (j >= SC + STC + 1) chk("checksum", {16'd0, cfg_checksum}, {16'd0, exp_cs});
        end
        cfg_start = 1'b0;
        chk("wr_err_sticky", {63'd0, tbl_wr_err}, {63'd0, (we_at >= 0)});
        xfers = k;
        csum  = cfg_checksum;
    endtask

    initial begin
        vec_t          vecs [7];
        int            got;
        logic [PW-1:0] cs;
        logic [63:0]   r64;
        logic [PW-1:0] exp6;

        n_err = 0; n_chk = 0;
        reset_n = 1'b0; tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
        num_pkts = '0; cfg_start = 1'b0; leaf_ready = 1'b0;
        repeat (3) tick();
        chk("rst_leaf", {15'd0, leaf_out}, 64'd0);
        chk("rst_ap_start", {63'd0, ap_start}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_cfg_done", {63'd0, cfg_done}, 64'd0);
        chk("rst_wr_err", {63'd0, tbl_wr_err}, 64'd0);
        chk("rst_checksum", {16'd0, cfg_checksum}, 64'd0);
        reset_n = 1'b1;
        tick();

        for (int a = 0; a < 64; a++) begin
            r64 = {$urandom(), $urandom()};
            wr(a, r64[PW-1:0]);
        end
        wr(0, 48'h2000_9b100fe0);
        wr(1, 48'hb080_22480000);

        // Table-driven runs: {num_pkts, ready pattern, expected transfers}
        vecs[0] = '{48, 0, 48};
        vecs[1] = '{48, 2, 48};
        vecs[2] = '{0, 0, 0};
        vecs[3] = '{1, 0, 1};
        vecs[4] = '{64, 0, 64};
        vecs[5] = '{100, 1, 64};
        vecs[6] = '{127, 2, 64};
        for (int v = 0; v < 7; v++) begin
            run(vecs[v].n, vecs[v].rmode, -1, -1, 1'b0, got, cs);
            chk("xfer_count", 64'(got), 64'(vecs[v].exp_xfers));
        end

        // Reset while packet 5 is on the leaf, then a fresh run from entry 0.
        num_pkts = 7'd20; cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0; leaf_ready = 1'b1;
        repeat (7) tick();
        chk("t4_pkt5", {15'd0, leaf_out}, {15'd0, 1'b1, model_mem[5]});
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1; leaf_ready = 1'b0;
        chk("t4_leaf", {15'd0, leaf_out}, 64'd0);
        chk("t4_busy", {63'd0, busy}, 64'd0);
        chk("t4_ap_start", {63'd0, ap_start}, 64'd0);
        run(10, 0, -1, -1, 1'b0, got, cs);
        chk("t4_rerun_count", 64'(got), 64'd10);

        // Write while busy, plus cfg_start during START; next run clears the
        // error and starts together with a write to entry 0.
        run(12, 1, 5, SC + 4, 1'b0, got, cs);
        chk("t5_count", 64'(got), 64'd12);
        run(5, 1, -1, -1, 1'b1, got, cs);
        chk("t5_wr0_count", 64'(got), 64'd5);

        // Two-entry checksum.
        wr(0, 48'h1234);
        wr(1, 48'h00ff);
        run(2, 0, -1, -1, 1'b0, got, cs);
`ifdef CFG_CHECKSUM_EN
        exp6 = 48'h12cb;
`else
        exp6 = 48'h0;
`endif
        chk("t6_checksum", {16'd0, cs}, {16'd0, exp6});

        // Randomized runs over a partly rewritten table.
        for (int r = 0; r < 6; r++) begin
            int n;
            for (int w = 0; w < 8; w++) begin
                r64 = {$urandom(), $urandom()};
                wr(int'($urandom_range(0, 63)), r64[PW-1:0]);
            end
            n = int'($urandom_range(0, 90));
            run(n, 1, -1, -1, 1'b0, got, cs);
            chk("rand_count", 64'(got), 64'((n > 64) ? 64 : n));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
